tone_generator: RTL and testbench
=================================

Name: tone_generator

Overview:
Parametrised multi-mode audio tone source, the next generation of the single-channel square-wave generator. Produces a signed sample stream in one of three modes: square, variable-duty pulse, LFSR noise. Settings are double-buffered and applied only at period boundaries, so retuning is glitch-free. Sits between the note/sequencer control logic and the channel mixer.

Parameters:
PERIOD_WIDTH, 21, width of half_period in clock cycles.
SAMPLE_WIDTH, 16, width of volume and wave.
DUTY_WIDTH, 8, width of duty; fraction = duty / 2^DUTY_WIDTH.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
enable  in  1  run request, level-sensitive.
mode  in  2  0 square, 1 pulse, 2 noise, 3 reserved (silent).
half_period  in  PERIOD_WIDTH  half of tone period, in clocks.
duty  in  DUTY_WIDTH  pulse high fraction, mode 1 only.
volume  in  SAMPLE_WIDTH  unsigned amplitude.
wave  out  SAMPLE_WIDTH  signed two's-complement sample, registered.
cycle_start  out  1  one-clock pulse on the first cycle of each period.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- On reset (any time, including mid-period): state IDLE, cnt=0, wave=0, cycle_start=0, shadows=0, LFSR=16'hACE1.
- States: IDLE, RUN (plus STOPPING with the optional feature).
- IDLE: wave=0, cnt=0.
  - enable=1 -> RUN at the next edge.
  - Same edge: load shadows (mode_s, half_s, duty_s, vol_s), cnt=0, cycle_start=1.
- RUN, general:
  - P = 2*half_s, PERIOD_WIDTH+1 bits.
  - cnt increments each clock.
  - When cnt == P-1: next cnt=0, reload all shadows, cycle_start=1 on that edge.
  - Input changes mid-period have no effect until the wrap.
- RUN, half_s == 0:
  - wave=0, cnt held 0, cycle_start=0.
  - Shadows reload every cycle, so a nonzero value takes effect on the following edge, with cycle_start=1.
- RUN, enable=0: next edge -> IDLE, wave=0 (immediate mute).
- Amplitude:
  - V = min(vol_s, 2^(SAMPLE_WIDTH-1)-1), saturating.
  - High = +V, low = -V.
- wave is registered and computed from the cnt/shadow values taken on the same edge. Zero added latency: the first RUN cycle already shows the cnt=0 sample.
- Mode 0 (square): high while cnt < half_s, else low.
- Mode 1 (pulse):
  - T = (P*duty_s) >> DUTY_WIDTH, computed from shadows and held for the period.
  - High while cnt < T.
  - duty_s=0 -> always low.
- Mode 2 (noise):
  - 16-bit Galois LFSR, taps mask 16'hB400.
  - Steps on each edge where the new cnt == 0 or the new cnt == half_s.
  - wave = high if LFSR[0]=1, else low, using the post-step LFSR value.
  - LFSR is not reset on mode change.
- Mode 3: wave=0, counter runs normally, cycle_start still pulses.
- cycle_start is 0 at all other times.

Optional Feature:
Macro TONE_GENERATOR_SOFT_STOP_EN.
- Defined: enable=0 in RUN -> STOPPING. STOPPING continues the waveform until cnt == P-1, then goes to IDLE with wave=0 and no cycle_start. enable=1 in STOPPING returns to RUN with no disturbance to cnt.
- Undefined: immediate mute as above; STOPPING state absent.

Decomposition:
- Package tone_generator_pkg holds:
  - mode enum: MODE_SQUARE=0, MODE_PULSE=1, MODE_NOISE=2, MODE_OFF=3.
  - state enum.
  - LFSR_SEED=16'hACE1, LFSR_TAPS=16'hB400.
- One natural sub-module: tone_lfsr, a 16-bit Galois LFSR with synchronous reset/seed and a step enable.

Test Plan:
- Reset pulse, then enable=1, mode=0, half_period=10, volume=16'h00FF -> wave=+255 for 10 clocks, -255 for 10 clocks, repeating; cycle_start every 20 clocks, first on the RUN entry edge.
- mode=1, half_period=10, duty=64 -> P=20, T=5; wave=+255 for 5 clocks, -255 for 15; duty=0 -> constant -255.
- Change half_period 10->4 at cnt=3 -> current period still lasts 20 clocks; next periods last 8 clocks (4 high / 4 low).
- volume=16'hFFFF -> wave alternates 32767 / -32767; half_period=0 -> wave=0, no cycle_start.
- enable 1->0 at cnt=5 -> without macro, wave=0 from the next edge; with TONE_GENERATOR_SOFT_STOP_EN, waveform continues to cnt=19, then wave=0. Reset asserted mid-period -> all outputs 0 on the next edge.
- mode=2, half_period=2, after reset -> LFSR steps every 2 clocks from 16'hACE1. Bench compares the sign of wave against a reference model of the LFSR sequence.

Source files
------------

// File: rtl/tone_generator_pkg.sv
// tone_generator_pkg: shared mode/state encodings and LFSR constants for tone_generator
package tone_generator_pkg;
  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_NOISE  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/tone_lfsr.sv
// tone_lfsr: 16-bit Galois LFSR with seed on reset, step enable and post-step output bit
module tone_lfsr
  import tone_generator_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic sample_bit
);
  logic [15:0] value, stepped;
  assign stepped = lfsr_next(value);
  assign sample_bit = step ? stepped[0] : value[0];
  // seeded shift register advancing only when stepped
  always_ff @(posedge clk) begin
    if (rst) value <= LFSR_SEED;
    else if (step) value <= stepped;
  end
endmodule

// File: rtl/tone_generator.sv
// tone_generator: square/pulse/noise tone source with period-boundary retuning; TONE_GENERATOR_SOFT_STOP_EN finishes the period before muting
module tone_generator
  import tone_generator_pkg::*;
#(
  parameter int PERIOD_WIDTH = 21,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DUTY_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [PERIOD_WIDTH-1:0] half_period,
  input  logic [DUTY_WIDTH-1:0]   duty,
  input  logic [SAMPLE_WIDTH-1:0] volume,
  output logic [SAMPLE_WIDTH-1:0] wave,
  output logic                    cycle_start
);
  localparam logic [SAMPLE_WIDTH-1:0] MAX_AMP = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  state_e state, nxt_state;
  mode_e mode_s, nxt_mode;
  logic [PERIOD_WIDTH-1:0] half_s, nxt_half;
  logic [DUTY_WIDTH-1:0] duty_s, nxt_duty;
  logic [SAMPLE_WIDTH-1:0] vol_s, nxt_vol, amp, nxt_wave;
  logic [PERIOD_WIDTH:0] cnt, nxt_cnt;
  logic [PERIOD_WIDTH+DUTY_WIDTH:0] thr;
  logic active, wrap, run_next, load, hot, step, noise_bit, high, nxt_cs;

  tone_lfsr u_lfsr (
    .clk       (clock),
    .rst       (reset),
    .step      (step),
    .sample_bit(noise_bit)
  );

  // state, shadows, counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mode_s      <= MODE_SQUARE;
      half_s      <= '0;
      duty_s      <= '0;
      vol_s       <= '0;
      wave        <= '0;
      cycle_start <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      mode_s      <= nxt_mode;
      half_s      <= nxt_half;
      duty_s      <= nxt_duty;
      vol_s       <= nxt_vol;
      wave        <= nxt_wave;
      cycle_start <= nxt_cs;
    end
  end

  // next state; a zero half period counts as a boundary every cycle
  always_comb begin
    active = state != ST_IDLE;
    wrap = active ? (half_s == '0 || cnt == {half_s, 1'b0} - 1'b1) : enable;
`ifdef TONE_GENERATOR_SOFT_STOP_EN
    nxt_state = enable ? ST_RUN : (active && !wrap) ? ST_STOPPING : ST_IDLE;
`else
    nxt_state = enable ? ST_RUN : ST_IDLE;
`endif
  end

  // shadow reload at boundaries, counter advance and noise stepping
  always_comb begin
    run_next = nxt_state != ST_IDLE;
    load = run_next && wrap;
    nxt_mode = load ? mode_e'(mode) : mode_s;
    nxt_half = load ? half_period : half_s;
    nxt_duty = load ? duty : duty_s;
    nxt_vol = load ? volume : vol_s;
    nxt_cnt = (load || !run_next) ? '0 : cnt + 1'b1;
    hot = run_next && nxt_half != '0;
    nxt_cs = hot && wrap;
    step = hot && nxt_mode == MODE_NOISE && (nxt_cnt == '0 || nxt_cnt == {1'b0, nxt_half});
  end

  // sample for the cycle about to start, from the new counter and shadows
  always_comb begin
    thr = ({{DUTY_WIDTH{1'b0}}, nxt_half, 1'b0} * {{(PERIOD_WIDTH+1){1'b0}}, nxt_duty}) >> DUTY_WIDTH;
    high = nxt_mode == MODE_SQUARE ? nxt_cnt < {1'b0, nxt_half} :
           nxt_mode == MODE_PULSE ? {{DUTY_WIDTH{1'b0}}, nxt_cnt} < thr : noise_bit;
    amp = nxt_vol > MAX_AMP ? MAX_AMP : nxt_vol;
    nxt_wave = (!hot || nxt_mode == MODE_OFF) ? '0 : high ? amp : -amp;
  end
endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: randomized tone_generator bench against a behavioural period model
module tb_tone_generator;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [20:0] half_period = '0;
  logic [7:0] duty = '0;
  logic [15:0] volume = '0;
  logic [15:0] wave;
  logic cycle_start;
  int total = 0;
  int bad = 0;
  int m_state, m_cnt, s_mode, s_half, s_duty, s_vol, e_wave, e_cs;
  logic [15:0] m_lfsr;

  always #5 clock = ~clock;

  tone_generator dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .half_period(half_period), .duty(duty), .volume(volume),
    .wave(wave), .cycle_start(cycle_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int n, v, p;
    bit act, bnd, live, hi;
    if (reset) begin
      m_state = 0; m_cnt = 0; s_mode = 0; s_half = 0; s_duty = 0; s_vol = 0;
      m_lfsr = 16'hACE1; e_wave = 0; e_cs = 0;
      return;
    end
    act = m_state != 0;
    bnd = act ? (s_half == 0 || m_cnt == 2 * s_half - 1) : enable;
    if (enable) n = 1;
`ifdef TONE_GENERATOR_SOFT_STOP_EN
    else n = (act && !bnd) ? 2 : 0;
`else
    else n = 0;
`endif
    if (n != 0 && bnd) begin
      s_mode = mode; s_half = half_period; s_duty = duty; s_vol = volume; m_cnt = 0;
    end else if (n != 0) m_cnt++;
    else m_cnt = 0;
    m_state = n;
    live = n != 0 && s_half != 0;
    e_cs = (live && bnd) ? 1 : 0;
    if (live && s_mode == 2 && (m_cnt == 0 || m_cnt == s_half))
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    p = 2 * s_half;
    v = s_vol > 32767 ? 32767 : s_vol;
    case (s_mode)
      0: hi = m_cnt < s_half;
      1: hi = longint'(m_cnt) < (longint'(p) * s_duty) / 256;
      2: hi = m_lfsr[0];
      default: hi = 0;
    endcase
    e_wave = (!live || s_mode == 3) ? 0 : hi ? v : -v;
  endtask

  task automatic cycle();
    logic [15:0] ew;
    model_edge();
    @(negedge clock);
    ew = 16'(e_wave);
    check("wave", {16'h0, wave}, {16'h0, ew});
    check("cycle_start", {31'h0, cycle_start}, e_cs);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0; enable = 1'b1; mode = 2'd0; half_period = 21'd10; volume = 16'h00FF;
    repeat (60) cycle();
    mode = 2'd1; duty = 8'd64;
    repeat (60) cycle();
    duty = 8'd0;
    repeat (40) cycle();
    mode = 2'd0; duty = 8'd64;
    repeat (3) cycle();
    half_period = 21'd4;
    repeat (40) cycle();
    volume = 16'hFFFF;
    repeat (30) cycle();
    half_period = 21'd0;
    repeat (10) cycle();
    half_period = 21'd10;
    repeat (26) cycle();
    enable = 1'b0;
    repeat (30) cycle();
    enable = 1'b1;
    repeat (27) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; mode = 2'd2; half_period = 21'd2; volume = 16'h00FF;
    repeat (60) cycle();
    mode = 2'd3;
    repeat (20) cycle();
    repeat (5000) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0)
        case ($urandom_range(0, 5))
          0: half_period = 21'd0;
          1: half_period = 21'd1;
          2: half_period = 21'd2;
          3: half_period = 21'd4;
          4: half_period = 21'd10;
          default: half_period = 21'($urandom_range(3, 25));
        endcase
      if ($urandom_range(0, 29) == 0)
        case ($urandom_range(0, 3))
          0: duty = 8'd0;
          1: duty = 8'd255;
          default: duty = 8'($urandom_range(1, 254));
        endcase
      if ($urandom_range(0, 29) == 0)
        case ($urandom_range(0, 4))
          0: volume = 16'h00FF;
          1: volume = 16'hFFFF;
          2: volume = 16'h7FFF;
          3: volume = 16'h8000;
          default: volume = 16'($urandom);
        endcase
      reset = $urandom_range(0, 299) == 0;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
